// File: rtl/regbank_pkg.sv
// Shared constants and FSM encoding for the register-bank access sequencer.
// Also holds the maximum writeback burst allowed to hold off a pending read.
package regbank_pkg;

  localparam int NREGS         = 16;
  localparam int IDX_W         = 4;
  localparam int DATA_W        = 32;
  localparam int WB_MAX_CONSEC = 4;
  localparam int CONSEC_W      = $clog2(WB_MAX_CONSEC + 1);

  localparam logic [IDX_W-1:0] ZERO_IDX = 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ1 = 2'd1,
    READ2 = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/regbank_slot_arbiter.sv
// Picks the single bank slot each cycle: writeback first, unless a pending
// operand read has already been starved for WB_MAX_CONSEC slots.
module regbank_slot_arbiter
  import regbank_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  state_e            state,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  output logic              wr_slot,
  output logic              rd_slot,
  output logic [IDX_W-1:0]  bank_select,
  output logic              bank_write,
  output logic [DATA_W-1:0] bank_data_in
);

  logic [CONSEC_W-1:0] consec_q, consec_d;
  logic                read_phase;
  logic                wb_block;

  // Slot decision and bank mux; x0 writes take the slot but never strobe the bank.
  always_comb begin
    read_phase   = (state == READ1) || (state == READ2);
    wb_block     = read_phase && (consec_q == CONSEC_W'(WB_MAX_CONSEC));
    wb_ready     = !reset && !wb_block;
    wr_slot      = wb_valid && wb_ready;
    rd_slot      = !reset && read_phase && !wr_slot;
    bank_select  = ZERO_IDX;
    bank_write   = 1'b0;
    bank_data_in = '0;
    if (wr_slot) begin
      bank_select  = wb_idx;
      bank_write   = (wb_idx != ZERO_IDX);
      bank_data_in = wb_data;
    end else if (rd_slot) begin
      bank_select = rd_idx;
    end else begin
      bank_select = ZERO_IDX;
    end
  end

  // Consecutive-writeback counter, only meaningful while a read is pending.
  always_comb begin
    consec_d = consec_q;
    if (reset || rd_slot || (state == IDLE)) begin
      consec_d = '0;
    end else if (wr_slot && read_phase && (consec_q != CONSEC_W'(WB_MAX_CONSEC))) begin
      consec_d = consec_q + CONSEC_W'(1);
    end else begin
      consec_d = consec_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    consec_q <= consec_d;
  end

endmodule

// File: rtl/regbank_access_sequencer.sv
// Serializes rs1/rs2 operand reads over the shared single-port register bank
// and interleaves writeback writes through the slot arbiter.
module regbank_access_sequencer
  import regbank_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDX_W-1:0]  rs1_idx,
  input  logic [IDX_W-1:0]  rs2_idx,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_data,
  output logic [IDX_W-1:0]  bank_select,
  output logic              bank_write,
  output logic [DATA_W-1:0] bank_data_in,
  input  logic [DATA_W-1:0] bank_data_out
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    rs1_idx_q, rs1_idx_d;
  logic [IDX_W-1:0]    rs2_idx_q, rs2_idx_d;
  logic [DATA_W-1:0]   rs1_data_q, rs1_data_d;
  logic [DATA_W-1:0]   rs2_data_q, rs2_data_d;
  logic [IDX_W-1:0]    rd_idx;
  logic                wr_slot;
  logic                rd_slot;

  regbank_slot_arbiter u_arb (
    .clk          (clk),
    .reset        (reset),
    .state        (state_q),
    .rd_idx       (rd_idx),
    .wb_valid     (wb_valid),
    .wb_idx       (wb_idx),
    .wb_data      (wb_data),
    .wb_ready     (wb_ready),
    .wr_slot      (wr_slot),
    .rd_slot      (rd_slot),
    .bank_select  (bank_select),
    .bank_write   (bank_write),
    .bank_data_in (bank_data_in)
  );

  // Handshake outputs and the index presented for the current read slot.
  always_comb begin
    req_ready = !reset && (state_q == IDLE);
    op_valid  = !reset && (state_q == RESP);
    rs1_data  = rs1_data_q;
    rs2_data  = rs2_data_q;
    if (state_q == READ2) begin
      rd_idx = rs2_idx_q;
    end else begin
      rd_idx = rs1_idx_q;
    end
  end

  // Operand FSM: reads are skipped for x0 and for rs2 == rs1.
  always_comb begin
    state_d    = state_q;
    rs1_idx_d  = rs1_idx_q;
    rs2_idx_d  = rs2_idx_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    if (reset) begin
      state_d    = IDLE;
      rs1_idx_d  = ZERO_IDX;
      rs2_idx_d  = ZERO_IDX;
      rs1_data_d = '0;
      rs2_data_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            rs1_idx_d = rs1_idx;
            rs2_idx_d = rs2_idx;
            if ((rs1_idx == ZERO_IDX) && (rs2_idx == ZERO_IDX)) begin
              rs1_data_d = '0;
              rs2_data_d = '0;
              state_d    = RESP;
            end else if (rs1_idx == ZERO_IDX) begin
              rs1_data_d = '0;
              state_d    = READ2;
            end else begin
              state_d = READ1;
            end
          end else begin
            state_d = IDLE;
          end
        end
        READ1: begin
          if (rd_slot) begin
            rs1_data_d = bank_data_out;
            if (rs2_idx_q == ZERO_IDX) begin
              rs2_data_d = '0;
              state_d    = RESP;
            end else if (rs2_idx_q == rs1_idx_q) begin
              rs2_data_d = bank_data_out;
              state_d    = RESP;
            end else begin
              state_d = READ2;
            end
          end else begin
            state_d = READ1;
          end
        end
        READ2: begin
          if (rd_slot) begin
            rs2_data_d = bank_data_out;
            state_d    = RESP;
          end else begin
            state_d = READ2;
          end
        end
        RESP: begin
          if (op_ready) begin
            state_d = IDLE;
          end else begin
            state_d = RESP;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and operand registers.
  always_ff @(posedge clk) begin
    state_q    <= state_d;
    rs1_idx_q  <= rs1_idx_d;
    rs2_idx_q  <= rs2_idx_d;
    rs1_data_q <= rs1_data_d;
    rs2_data_q <= rs2_data_d;
  end

endmodule

// File: tb/tb_regbank_access_sequencer.sv
// Directed bench for regbank_access_sequencer with a behavioural 16x32 bank;
// expected operands/latencies are queued at issue and checked by a monitor.
module tb_regbank_access_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  rs1_idx = 4'd0;
  logic [3:0]  rs2_idx = 4'd0;
  logic        op_valid;
  logic        op_ready = 1'b1;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [3:0]  wb_idx = 4'd0;
  logic [31:0] wb_data = 32'd0;
  logic [3:0]  bank_select;
  logic        bank_write;
  logic [31:0] bank_data_in;
  logic [31:0] bank_data_out;

  logic [31:0] bank_mem [16];
  int          cyc = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic        stream_on = 1'b0;
  int          lows[$];

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb_q[$];

  regbank_access_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .rs1_idx       (rs1_idx),
    .rs2_idx       (rs2_idx),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_idx        (wb_idx),
    .wb_data       (wb_data),
    .bank_select   (bank_select),
    .bank_write    (bank_write),
    .bank_data_in  (bank_data_in),
    .bank_data_out (bank_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural bank: clocked write, combinational read.
  always @(posedge clk) if (bank_write) bank_mem[bank_select] <= bank_data_in;
  assign bank_data_out = bank_mem[bank_select];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: pop and compare whenever operands are handed over.
  always @(negedge clk) begin
    if (!reset && op_valid && op_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_op_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rs1_data", rs1_data, e.r1);
        chk("rs2_data", rs2_data, e.r2);
        chk("op_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  task automatic do_req(input logic [3:0] a, input logic [3:0] b,
                        input logic [31:0] e1, input logic [31:0] e2, input int lat);
    int n;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; rs1_idx = a; rs2_idx = b;
    #1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
    e.r1 = e1; e.r2 = e2; e.lat = lat; e.acc = cyc + 1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (sb_q.size() != 0) begin
      chk("op_valid_timeout", 32'd0, 32'd1);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_wb(input logic [3:0] idx, input logic [31:0] data);
    int n;
    @(negedge clk);
    wb_valid = 1'b1; wb_idx = idx; wb_data = data;
    #1;
    n = 0;
    while (!wb_ready && n < 50) begin @(negedge clk); #1; n++; end
    chk("wb_ready", 32'(wb_ready), 32'd1);
    chk("bank_write", 32'(bank_write), (idx != 4'd0) ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] x12_before;
    for (int i = 0; i < 16; i++) bank_mem[i] = 32'd0;

    // Reset behaviour
    wb_valid = 1'b1; wb_idx = 4'd5; wb_data = 32'h5555_5555;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_wb_ready", 32'(wb_ready), 32'd0);
    chk("rst_bank_write", 32'(bank_write), 32'd0);
    reset = 1'b0; wb_valid = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_op_valid", 32'(op_valid), 32'd0);
    chk("post_rst_rs1_data", rs1_data, 32'd0);
    chk("post_rst_rs2_data", rs2_data, 32'd0);
    chk("post_rst_wb_ready", 32'(wb_ready), 32'd1);

    // Two distinct registers, one of them never written
    do_wb(4'd3, 32'hDEAD_BEEF);
    do_req(4'd3, 4'd5, 32'hDEAD_BEEF, 32'd0, 3);

    // Both x0: no read slot, response next cycle
    do_req(4'd0, 4'd0, 32'd0, 32'd0, 1);

    // Same register twice: single read slot
    do_wb(4'd7, 32'h0000_1234);
    do_req(4'd7, 4'd7, 32'h0000_1234, 32'h0000_1234, 2);

    // Continuous writeback while reading x2/x4
    do_wb(4'd2, 32'h2222_0002);
    do_wb(4'd4, 32'h4444_0004);
    stream_on = 1'b1;
    lows.delete();
    fork
      begin
        int k;
        k = 0;
        while (stream_on && k < 200) begin
          @(negedge clk);
          wb_valid = 1'b1; wb_idx = 4'(8 + (k % 8)); wb_data = 32'hA000_0000 + 32'(k);
          #1;
          if (!wb_ready) lows.push_back(cyc);
          k++;
        end
        @(negedge clk);
        wb_valid = 1'b0;
      end
      begin
        do_req(4'd2, 4'd4, 32'h2222_0002, 32'h4444_0004, 11);
        stream_on = 1'b0;
      end
    join
    chk("wb_ready_low_count", 32'(lows.size()), 32'd2);
    if (lows.size() == 2) chk("wb_ready_low_spacing", 32'(lows[1] - lows[0]), 32'd5);

    // Writeback to x0 is accepted but dropped
    do_wb(4'd0, 32'hFFFF_FFFF);
    do_wb(4'd6, 32'h0000_0666);
    do_req(4'd0, 4'd6, 32'd0, 32'h0000_0666, 2);
    do_wb(4'd9, 32'h0999_0000);
    do_req(4'd9, 4'd0, 32'h0999_0000, 32'd0, 2);

    // Reset while in READ2
    x12_before = bank_mem[12];
    @(negedge clk);
    req_valid = 1'b1; rs1_idx = 4'd10; rs2_idx = 4'd11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; wb_valid = 1'b1; wb_idx = 4'd12; wb_data = 32'hBAD0_BAD0;
    #1;
    chk("midrst_bank_write", 32'(bank_write), 32'd0);
    chk("midrst_wb_ready", 32'(wb_ready), 32'd0);
    chk("midrst_op_valid", 32'(op_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0; wb_valid = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_op_valid_after", 32'(op_valid), 32'd0);
    chk("midrst_rs1_cleared", rs1_data, 32'd0);
    chk("midrst_x12_unchanged", bank_mem[12], x12_before);

    // Normal operation resumes
    do_req(4'd7, 4'd3, 32'h0000_1234, 32'hDEAD_BEEF, 3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
